// File: rtl/data_memory_unit_if.sv
// data_memory_unit_if
// Groups the MEM-stage access bus of the data memory: request, store data,
// load result and status flags. clk/reset remain plain module ports.
interface data_memory_unit_if #(
  parameter int ADDR_W = 32
);
  logic              MemWrite;
  logic              MemRead;
  logic [2:0]        funct3;
  logic [ADDR_W-1:0] read_address;
  logic [31:0]       Write_data;
  logic [31:0]       MemData_out;
  logic              mem_busy;
  logic              misaligned;

  // Pipeline side: issues accesses, consumes results
  modport master (
    output MemWrite, MemRead, funct3, read_address, Write_data,
    input  MemData_out, mem_busy, misaligned
  );

  // Memory side
  modport slave (
    input  MemWrite, MemRead, funct3, read_address, Write_data,
    output MemData_out, mem_busy, misaligned
  );
endinterface

// File: rtl/data_memory_unit.sv
// data_memory_unit
// Byte-addressable RV32 data memory (DEPTH x 32-bit words) with B/H/W loads
// and stores, sign/zero extension, registered 1-cycle load data and an
// internal zero-fill sequencer that runs after every reset.
//
// Optional build macro: DMEM_MISALIGN_CHK_EN
//   defined   -> misaligned halfword/word accesses are rejected and flagged
//   undefined -> misaligned halfword/word accesses are force-aligned
//
// state    | meaning
// ---------+---------------------------------------------------------------
// ST_CLEAR | zero-filling word[r_clr_cnt]; accesses ignored, mem_busy = 1
// ST_READY | normal load/store service, mem_busy = 0
module data_memory_unit #(
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 32
) (
  input  logic               clk,
  input  logic               reset,
  data_memory_unit_if.slave  bus
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic {
    ST_CLEAR,
    ST_READY
  } state_t;

  state_t          r_state;
  logic [AW-1:0]   r_clr_cnt;
  logic            r_busy;
  logic [31:0]     r_data;
  logic            r_misaligned;
  logic [31:0]     r_mem [DEPTH];

  logic [ADDR_W-1:0] w_addr_full;
  logic [AW+1:0]     w_addr;
  logic [AW-1:0]     w_idx;
  logic [1:0]        w_lane;
  logic              w_unused_addr;
  logic              w_is_half;
  logic              w_is_word;
  logic              w_f3_legal;
  logic              w_mis_addr;
  logic              w_req;
  logic              w_reject;
  logic              w_st_we;
  logic              w_clr_we;
  logic [3:0]        w_be;
  logic [31:0]       w_mask;
  logic [31:0]       w_wdata;
  logic [31:0]       w_rd_word;
  logic [31:0]       w_merged;
  logic [7:0]        w_byte;
  logic [15:0]       w_half;
  logic [31:0]       w_load;

  // Address decode: upper bits are ignored so accesses wrap modulo DEPTH*4
  assign w_addr_full   = bus.read_address;
  assign w_addr        = w_addr_full[AW+1:0];
  assign w_idx         = w_addr[AW+1:2];
  assign w_unused_addr = ^w_addr_full[ADDR_W-1:AW+2];

  assign w_is_half  = (bus.funct3[1:0] == 2'b01);
  assign w_is_word  = (bus.funct3[1:0] == 2'b10);
  assign w_f3_legal = (bus.funct3 == 3'b000) || (bus.funct3 == 3'b001) ||
                      (bus.funct3 == 3'b010) || (bus.funct3 == 3'b100) ||
                      (bus.funct3 == 3'b101);

`ifdef DMEM_MISALIGN_CHK_EN
  assign w_mis_addr = (w_is_half && w_addr[0]) ||
                      (w_is_word && (w_addr[1:0] != 2'b00));
  assign w_lane     = w_addr[1:0];
`else
  assign w_mis_addr = 1'b0;
  assign w_lane     = w_is_word ? 2'b00 :
                      w_is_half ? {w_addr[1], 1'b0} : w_addr[1:0];
`endif

  assign w_req    = bus.MemRead || bus.MemWrite;
  assign w_reject = w_req && (!w_f3_legal || w_mis_addr);
  assign w_st_we  = (r_state == ST_READY) && bus.MemWrite && !w_reject;
  assign w_clr_we = (r_state == ST_CLEAR);

  // Store byte enables and lane-replicated store data
  always_comb begin
    w_be    = 4'b0000;
    w_wdata = bus.Write_data;
    if (w_is_word) begin
      w_be    = 4'b1111;
      w_wdata = bus.Write_data;
    end else if (w_is_half) begin
      w_be    = w_lane[1] ? 4'b1100 : 4'b0011;
      w_wdata = {2{bus.Write_data[15:0]}};
    end else begin
      w_be    = 4'b0001 << w_lane;
      w_wdata = {4{bus.Write_data[7:0]}};
    end
  end

  assign w_mask    = {{8{w_be[3]}}, {8{w_be[2]}}, {8{w_be[1]}}, {8{w_be[0]}}};
  assign w_rd_word = r_mem[w_idx];
  assign w_merged  = (w_rd_word & ~w_mask) | (w_wdata & w_mask);

  // Lane selection and sign/zero extension of the pre-write word
  always_comb begin
    w_byte = w_rd_word[7:0];
    case (w_lane)
      2'd0:    w_byte = w_rd_word[7:0];
      2'd1:    w_byte = w_rd_word[15:8];
      2'd2:    w_byte = w_rd_word[23:16];
      default: w_byte = w_rd_word[31:24];
    endcase
    w_half = w_lane[1] ? w_rd_word[31:16] : w_rd_word[15:0];
    case (bus.funct3)
      3'b000:  w_load = {{24{w_byte[7]}}, w_byte};
      3'b100:  w_load = {24'h0, w_byte};
      3'b001:  w_load = {{16{w_half[15]}}, w_half};
      3'b101:  w_load = {16'h0, w_half};
      3'b010:  w_load = w_rd_word;
      default: w_load = 32'h0;
    endcase
  end

  // Storage array: zero-fill during clear, masked merge on accepted stores
  always_ff @(posedge clk) begin
    if (w_clr_we) begin
      r_mem[r_clr_cnt] <= 32'h0;
    end else if (w_st_we) begin
      r_mem[w_idx] <= w_merged;
    end
  end

  // Control FSM with registered load data and status flags
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= ST_CLEAR;
      r_clr_cnt    <= '0;
      r_busy       <= 1'b1;
      r_data       <= 32'h0;
      r_misaligned <= 1'b0;
    end else begin
      case (r_state)
        ST_CLEAR: begin
          r_data       <= 32'h0;
          r_misaligned <= 1'b0;
          if (r_clr_cnt == AW'(DEPTH - 1)) begin
            r_state   <= ST_READY;
            r_busy    <= 1'b0;
            r_clr_cnt <= '0;
          end else begin
            r_clr_cnt <= r_clr_cnt + 1'b1;
          end
        end
        default: begin
          r_busy       <= 1'b0;
          r_misaligned <= w_reject;
          r_data       <= (bus.MemRead && !w_reject) ? w_load : 32'h0;
        end
      endcase
    end
  end

  assign bus.MemData_out = r_data;
  assign bus.mem_busy    = r_busy;
  assign bus.misaligned  = r_misaligned;

endmodule
